// File: rtl/servo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : servo_pkg                                                        |
// | Brief   : Shared state encoding, tick defaults and position type for the   |
// |           servo PWM scheduler.                                             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package servo_pkg;

    localparam int c_POS_W       = 6;
    localparam int c_FRAME_TICKS = 800;
    localparam int c_MIN_TICKS   = 40;
    localparam int c_SPAN_TICKS  = 40;

    typedef logic [c_POS_W-1:0] pos_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic pos_t sat_pos(input pos_t p, input int span);
        return (int'(p) > span) ? pos_t'(span) : p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/servo_pos_regs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : servo_pos_regs                                                   |
// | Brief   : Per-channel shadow/active position bank with write saturation;  |
// |           actives are refreshed from the shadows on the frame load strobe. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module servo_pos_regs
    import servo_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int SPAN_TICKS = c_SPAN_TICKS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      pos_valid,
    input  logic [1:0]                pos_ch,
    input  logic [c_POS_W-1:0]        pos_data,
    output logic                      pos_ready,
    output logic [N_CH*c_POS_W-1:0]   active
);

    localparam pos_t c_CENTRE = pos_t'(SPAN_TICKS / 2);

    logic w_wr;
    pos_t w_wdata;

    // The load cycle is the only cycle in which a write could race the copy.
    assign pos_ready = ~load;
    assign w_wr      = pos_valid & pos_ready;
    assign w_wdata   = sat_pos(pos_data, SPAN_TICKS);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            pos_t r_shadow;
            pos_t r_active;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_shadow <= c_CENTRE;
                    r_active <= c_CENTRE;
                end else begin
                    if (w_wr && (pos_ch == 2'(gi))) begin
                        r_shadow <= w_wdata;
                    end
                    if (load) begin
                        r_active <= r_shadow;
                    end
                end
            end

            assign active[gi*c_POS_W +: c_POS_W] = r_active;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/servo_pwm_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : servo_pwm_sched                                                  |
// | Brief   : Fixed-length frame scheduler emitting sequential servo pulses,   |
// |           one channel after another, on a tick clock enable.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module servo_pwm_sched
    import servo_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int FRAME_TICKS = c_FRAME_TICKS,
    parameter int MIN_TICKS   = c_MIN_TICKS,
    parameter int SPAN_TICKS  = c_SPAN_TICKS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_en,
    input  logic                enable,
    input  logic                pos_valid,
    input  logic [1:0]          pos_ch,
    input  logic [c_POS_W-1:0]  pos_data,
    output logic                pos_ready,
    output logic [N_CH-1:0]     pwm_out,
    output logic                frame_start,
    output logic                busy
);

    localparam int c_FRAME_W = $clog2(FRAME_TICKS);
    localparam int c_PULSE_W = $clog2(MIN_TICKS + SPAN_TICKS + 1);
    localparam int c_CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [c_FRAME_W-1:0] c_FRAME_END = c_FRAME_W'(FRAME_TICKS - 1);
    localparam logic [c_CH_W-1:0]    c_LAST_CH   = c_CH_W'(N_CH - 1);

    generate
        if (N_CH < 1 || N_CH > 4) begin : g_bad_nch
            $error("servo_pwm_sched: N_CH must be in 1..4");
        end
        if (N_CH * (MIN_TICKS + SPAN_TICKS) >= FRAME_TICKS) begin : g_bad_frame
            $error("servo_pwm_sched: all pulses must fit inside one frame");
        end
        if (SPAN_TICKS >= (1 << c_POS_W)) begin : g_bad_span
            $error("servo_pwm_sched: SPAN_TICKS exceeds the position type");
        end
    endgenerate

    state_t                 r_state,     w_state_nxt;
    logic [c_FRAME_W-1:0]   r_frame_cnt, w_frame_nxt;
    logic [c_PULSE_W-1:0]   r_pulse_cnt, w_pulse_nxt;
    logic [c_CH_W-1:0]      r_ch_idx,    w_ch_nxt;

    logic                   w_frame_end;
    logic                   w_load;
    logic [N_CH*c_POS_W-1:0] w_active_flat;
    pos_t                   w_act;
    logic [c_PULSE_W-1:0]   w_width_m1;

    assign w_frame_end = (r_frame_cnt == c_FRAME_END);
    // Gated by rst so frame_start stays low while reset is held.
    assign w_load = rst & tick_en & enable &
                    ((r_state == ST_IDLE) | ((r_state == ST_GAP) & w_frame_end));

    servo_pos_regs #(
        .N_CH       (N_CH),
        .SPAN_TICKS (SPAN_TICKS)
    ) u_pos_regs (
        .clk        (clk),
        .rst        (rst),
        .load       (w_load),
        .pos_valid  (pos_valid),
        .pos_ch     (pos_ch),
        .pos_data   (pos_data),
        .pos_ready  (pos_ready),
        .active     (w_active_flat)
    );

    always_comb begin
        w_act = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (r_ch_idx == c_CH_W'(i)) begin
                w_act = w_active_flat[i*c_POS_W +: c_POS_W];
            end
        end
    end

    assign w_width_m1 = c_PULSE_W'(MIN_TICKS) + c_PULSE_W'(w_act) - c_PULSE_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_frame_cnt <= '0;
            r_pulse_cnt <= '0;
            r_ch_idx    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_frame_nxt;
            r_pulse_cnt <= w_pulse_nxt;
            r_ch_idx    <= w_ch_nxt;
        end
    end

    // The frame counter runs through PULSE and GAP so the frame length
    // never depends on the programmed positions.
    always_comb begin
        w_state_nxt = r_state;
        w_frame_nxt = r_frame_cnt;
        w_pulse_nxt = r_pulse_cnt;
        w_ch_nxt    = r_ch_idx;
        if (tick_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        w_state_nxt = ST_PULSE;
                        w_frame_nxt = '0;
                        w_pulse_nxt = '0;
                        w_ch_nxt    = '0;
                    end
                end
                ST_PULSE: begin
                    w_frame_nxt = r_frame_cnt + c_FRAME_W'(1);
                    if (r_pulse_cnt == w_width_m1) begin
                        w_pulse_nxt = '0;
                        if (r_ch_idx == c_LAST_CH) begin
                            w_state_nxt = ST_GAP;
                        end else begin
                            w_ch_nxt = r_ch_idx + c_CH_W'(1);
                        end
                    end else begin
                        w_pulse_nxt = r_pulse_cnt + c_PULSE_W'(1);
                    end
                end
                ST_GAP: begin
                    if (w_frame_end) begin
                        w_state_nxt = enable ? ST_PULSE : ST_IDLE;
                        w_frame_nxt = '0;
                        w_pulse_nxt = '0;
                        w_ch_nxt    = '0;
                    end else begin
                        w_frame_nxt = r_frame_cnt + c_FRAME_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_pwm
            assign pwm_out[gi] = (r_state == ST_PULSE) && (r_ch_idx == c_CH_W'(gi));
        end
    endgenerate

    assign frame_start = w_load;
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_servo_pwm_sched                                               |
// | Brief   : Frame-timeline reference model feeding a scoreboard that checks  |
// |           measured pulse widths, sequencing, frame length and pos_ready.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_servo_pwm_sched;

    localparam int N_CH     = 2;
    localparam int FRAME    = 800;
    localparam int MIN      = 40;
    localparam int SPAN     = 40;
    localparam int TICK_DIV = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             tick_en = 1'b0;
    logic             enable = 1'b0;
    logic             pos_valid = 1'b0;
    logic [1:0]       pos_ch = '0;
    logic [5:0]       pos_data = '0;
    logic             pos_ready;
    logic [N_CH-1:0]  pwm_out;
    logic             frame_start;
    logic             busy;

    servo_pwm_sched #(
        .N_CH        (N_CH),
        .FRAME_TICKS (FRAME),
        .MIN_TICKS   (MIN),
        .SPAN_TICKS  (SPAN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_en     (tick_en),
        .enable      (enable),
        .pos_valid   (pos_valid),
        .pos_ch      (pos_ch),
        .pos_data    (pos_data),
        .pos_ready   (pos_ready),
        .pwm_out     (pwm_out),
        .frame_start (frame_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: event not expected by the model", name);
    endtask

    // Reference model: frame timeline in ticks plus the programmed positions.
    int  m_shadow [N_CH];
    bit  m_in_frame = 0;
    int  m_t = 0;
    int  phase = 0;
    int  exp_w_q [$];
    bit  ready_q [$];

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) m_shadow[c] = SPAN / 2;
        m_in_frame = 0;
        m_t = 0;
        exp_w_q.delete();
        ready_q.delete();
    endtask

    task automatic step(output bit accepted);
        bit tick;
        bit load;
        tick    = (phase == 0);
        phase   = (phase + 1) % TICK_DIV;
        tick_en = tick;
        load    = rst && tick && enable && (!m_in_frame || m_t == FRAME - 1);
        accepted = 0;
        if (pos_valid && rst) begin
            ready_q.push_back(!load);
            if (!load) begin
                accepted = 1;
                if (int'(pos_ch) < N_CH)
                    m_shadow[pos_ch] = (int'(pos_data) > SPAN) ? SPAN : int'(pos_data);
            end
        end
        if (load) begin
            for (int c = 0; c < N_CH; c++) exp_w_q.push_back(MIN + m_shadow[c]);
            m_in_frame = 1;
            m_t = 0;
        end else if (tick && m_in_frame) begin
            if (m_t == FRAME - 1) m_in_frame = 0;
            else m_t++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_ticks(input int n);
        bit acc;
        for (int i = 0; i < n * TICK_DIV; i++) step(acc);
    endtask

    task automatic run_until_t(input int target, input bit need_tick_next);
        bit acc;
        for (int i = 0; i < 3 * FRAME * TICK_DIV; i++) begin
            if (m_in_frame && m_t == target && (!need_tick_next || phase == 0)) return;
            step(acc);
        end
        fail_now("run_until_t timeout");
    endtask

    task automatic do_write(input int ch, input int data);
        bit acc;
        pos_valid = 1'b1;
        pos_ch    = 2'(ch);
        pos_data  = 6'(data);
        acc = 0;
        for (int i = 0; i < 4 && !acc; i++) step(acc);
        if (!acc) fail_now("write handshake timeout");
        pos_valid = 1'b0;
    endtask

    // Monitor: measures each DUT frame and scores it against the model queue.
    int cur_tick = 0;
    int start_tick = 0;
    int wcnt   [N_CH];
    int first_t[N_CH];
    int last_t [N_CH];
    bit have_frame = 0;
    bit overlap = 0;

    task automatic finalize(input int len);
        int prev_end;
        have_frame = 0;
        if (exp_w_q.size() < N_CH) begin
            fail_now("frame_without_expectation");
            return;
        end
        check("frame_len", len, FRAME);
        prev_end = start_tick;
        for (int c = 0; c < N_CH; c++) begin
            int e;
            e = exp_w_q.pop_front();
            check($sformatf("ch%0d_width", c), wcnt[c], e);
            check($sformatf("ch%0d_start", c), first_t[c], prev_end + 1);
            prev_end = last_t[c];
        end
        check("one_hot", int'(overlap), 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            have_frame = 0;
        end else begin
            if (pos_valid) begin
                if (ready_q.size() == 0) fail_now("pos_ready_unmodelled");
                else check("pos_ready", int'(pos_ready), int'(ready_q.pop_front()));
            end
            if (tick_en) begin
                if (have_frame && !busy) finalize(cur_tick - start_tick - 1);
                if (frame_start) begin
                    if (have_frame) finalize(cur_tick - start_tick);
                    have_frame = 1;
                    start_tick = cur_tick;
                    overlap = 0;
                    for (int c = 0; c < N_CH; c++) begin
                        wcnt[c] = 0;
                        first_t[c] = -1;
                        last_t[c] = -1;
                    end
                end else if (have_frame) begin
                    if ($countones(pwm_out) > 1) overlap = 1;
                    for (int c = 0; c < N_CH; c++) begin
                        if (pwm_out[c]) begin
                            if (wcnt[c] == 0) first_t[c] = cur_tick;
                            wcnt[c]++;
                            last_t[c] = cur_tick;
                        end
                    end
                end else if (pwm_out != '0) begin
                    fail_now("pwm_outside_frame");
                end
                cur_tick++;
            end
        end
    end

    initial begin
        #(10ns * 200000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        model_reset();
        rst = 1'b0;
        enable = 1'b1;
        tick_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_start", int'(frame_start), 0);
        check("rst_pos_ready", int'(pos_ready), 1);
        tick_en = 1'b0;
        rst = 1'b1;
        phase = 0;

        // Default centre positions: 60-tick pulses, 800-tick frames.
        run_ticks(2 * FRAME + 5);

        // Mid-frame writes only affect the following frame.
        run_until_t(100, 0);
        do_write(0, 0);
        do_write(1, 40);
        run_ticks(2 * FRAME);

        // Saturation and discarded out-of-range channel.
        do_write(1, 63);
        do_write(3, 5);
        run_ticks(2 * FRAME);

        // Random writes, including repeated writes to one channel.
        for (int k = 0; k < 40; k++) begin
            int gap;
            gap = int'($urandom_range(0, 300));
            for (int i = 0; i < gap; i++) step(acc);
            do_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 63)));
        end
        run_ticks(FRAME);

        // Write held across the load cycle.
        run_until_t(FRAME - 1, 1);
        do_write(0, 7);
        run_ticks(2 * FRAME);

        // Dropping enable mid-frame lets the frame finish, then idles.
        run_until_t(10, 0);
        enable = 1'b0;
        run_ticks(FRAME + 20);
        check("idle_busy", int'(busy), 0);
        check("idle_pwm", int'(pwm_out), 0);

        // Reset during the ch0 pulse.
        enable = 1'b1;
        run_until_t(20, 0);
        check("pre_rst_pwm0", int'(pwm_out[0]), 1);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_pwm", int'(pwm_out), 0);
        check("async_rst_busy", int'(busy), 0);
        model_reset();
        for (int i = 0; i < 5; i++) step(acc);
        rst = 1'b1;
        run_ticks(2 * FRAME + 5);

        enable = 1'b0;
        run_ticks(FRAME + 10);
        check("frames_outstanding", exp_w_q.size(), 0);
        check("ready_outstanding", ready_q.size(), 0);
        check("open_frame", int'(have_frame), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/servo_pwm_sched.md
SERVO_PWM_SCHED -- requirements
Module: servo_pwm_sched

Interface
REQ-001 Parameter N_CH, default 2: number of servo channels, range 1..4.
REQ-002 Parameter FRAME_TICKS, default 800: frame length in ticks (20 ms at 40 kHz).
REQ-003 Parameter MIN_TICKS, default 40: pulse width for position 0 (1 ms).
REQ-004 Parameter SPAN_TICKS, default 40: maximum pulse extension (2 ms total).
REQ-005 clk  input  1  system clock, 100 MHz.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 tick_en  input  1  single-cycle clock enable, one per 25 us.
REQ-008 enable  input  1  level; 1 = generate frames, 0 = stop at the next frame boundary.
REQ-009 pos_valid  input  1  position write request.
REQ-010 pos_ch  input  2  target channel index.
REQ-011 pos_data  input  6  requested position, 0..SPAN_TICKS.
REQ-012 pos_ready  output  1  write accepted when pos_valid && pos_ready at a clk edge.
REQ-013 pwm_out  output  N_CH  servo pulse outputs, one bit per channel.
REQ-014 frame_start  output  1  one-cycle pulse in the cycle that begins a frame.
REQ-015 busy  output  1  high while a frame is in progress.

Function
REQ-016 All state SHALL advance only in clk cycles where tick_en=1, except handshake capture, which works every cycle.
REQ-017 Each channel SHALL have a shadow register written on handshake and an active register loaded from the shadow at frame start.
REQ-018 pos_data above SPAN_TICKS SHALL saturate to SPAN_TICKS on capture; writes with pos_ch >= N_CH SHALL be accepted and discarded.
REQ-019 pos_ready SHALL be 0 only in the load cycle (IDLE/GAP with frame counter at its end and tick_en=1); it is 1 in all other cycles.
REQ-020 FSM states: IDLE, PULSE, GAP.
REQ-021 IDLE -> PULSE on a tick with enable=1: frame counter cleared, actives loaded, channel index = 0, frame_start=1 in that cycle.
REQ-022 PULSE: only pwm_out[ch_idx] is high; width = MIN_TICKS + active[ch_idx] ticks, then advance ch_idx; after the last channel -> GAP.
REQ-023 Channels SHALL be sequential with no gap ticks between them; at most one pwm_out bit is high at any time.
REQ-024 GAP: all pwm_out low until the frame counter reaches FRAME_TICKS-1; on the next tick go to PULSE (enable=1, new frame) or IDLE (enable=0).
REQ-025 Frame length SHALL be exactly FRAME_TICKS ticks, independent of positions.
REQ-026 Counter widths SHALL be derived with $clog2 from parameters; a compile-time check SHALL require N_CH*(MIN_TICKS+SPAN_TICKS) < FRAME_TICKS.
REQ-027 Deasserting enable mid-frame SHALL NOT truncate the frame.
REQ-028 A write that arrives mid-frame SHALL take effect from the next frame only.
REQ-029 Consecutive writes to the same channel in one frame: last write wins.
REQ-030 busy = (state != IDLE).

Reset
REQ-031 Asserting rst SHALL immediately force state=IDLE, pwm_out=0, frame_start=0, busy=0, and all counters to 0.
REQ-032 Shadow and active registers SHALL reset to SPAN_TICKS/2 (centre position, 1.5 ms).
REQ-033 Reset asserted mid-pulse SHALL drop pwm_out in the same instant; after release, the first frame starts on the first tick with enable=1.

Structure
REQ-034 Package servo_pkg SHALL hold the state enum, default tick constants, and the position type (6-bit).
REQ-035 A single sub-module, servo_pos_regs, SHALL hold the shadow/active register bank, saturation, and the load strobe; the FSM and counters stay in the top level.

Verification
REQ-036 Reset, enable=1, no writes -> per frame: ch0 high 60 ticks, then ch1 high 60 ticks, frame_start every 800 ticks.
REQ-037 Write ch0=0 and ch1=40 mid-frame -> current frame unchanged; next frame: ch0 high 40 ticks, ch1 high 80 ticks, frame still 800.
REQ-038 Write pos_data=63 to ch1 -> ch1 pulse 80 ticks; write pos_ch=3 with N_CH=2 -> no channel changes, handshake completes.
REQ-039 Hold pos_valid across the load cycle -> pos_ready=0 only in that cycle; write completes one cycle later and applies to the following frame.
REQ-040 Drop enable at tick 10 of a frame -> frame completes all 800 ticks, then IDLE, busy=0, no frame_start.
REQ-041 Assert rst during ch0 pulse -> pwm_out=0 immediately; after release, ch0 and ch1 both pulse 60 ticks in the first frame.
